// File: rtl/decode_pkg.sv
// Shared widths, the load opcode and field-offset helpers for the decode stage.
package decode_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_OPC_W       = 3;
  localparam int DEF_REG_ADDR_W  = 3;
  localparam int DEF_IMM_W       = 7;
  localparam int DEF_INSTR_W     = DEF_OPC_W + 2 * DEF_REG_ADDR_W + DEF_IMM_W;
  localparam int DEF_ZERO_REG    = 1;
  localparam int DEF_STALL_CNT_W = 16;

  localparam logic [DEF_OPC_W-1:0] DEF_LOAD_OPC = 3'b100;

  // Field layout at default widths: opc | rs | rt | imm (imm at bit 0).
  localparam int DEF_OPC_MSB = DEF_INSTR_W - 1;
  localparam int DEF_RS_MSB  = DEF_OPC_MSB - DEF_OPC_W;
  localparam int DEF_RT_MSB  = DEF_RS_MSB - DEF_REG_ADDR_W;
  localparam int DEF_IMM_MSB = DEF_IMM_W - 1;

  // What the ID/EX register does on the coming edge, in priority order.
  typedef enum logic [2:0] {
    ACT_HOLD   = 3'd0,
    ACT_FLUSH  = 3'd1,
    ACT_BUBBLE = 3'd2,
    ACT_LOAD   = 3'd3,
    ACT_DRAIN  = 3'd4
  } idexAction_e;

  // MSB of the rs field for an arbitrary parametrisation.
  function automatic int rsMsb(input int instrW, input int opcW);
    return instrW - opcW - 1;
  endfunction

  // MSB of the rt field for an arbitrary parametrisation.
  function automatic int rtMsb(input int instrW, input int opcW, input int regAddrW);
    return instrW - opcW - regAddrW - 1;
  endfunction

endpackage

// File: rtl/decode_stage_p_reg_file.sv
// Register file with two combinational read ports, one write port, and
// same-cycle write-back bypass onto both read ports.
module reg_file_bypass #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrEn,
  input  logic [REG_ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0]     wrData,
  input  logic [REG_ADDR_W-1:0] rdAddr1,
  input  logic [REG_ADDR_W-1:0] rdAddr2,
  output logic [DATA_W-1:0]     rdData1,
  output logic [DATA_W-1:0]     rdData2
);

  localparam int DEPTH = 1 << REG_ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wrBlocked;
  logic              wrLive;

  // Register 0 is hard-wired to zero when ZERO_REG is set: writes to it
  // are dropped and it never bypasses.
  assign wrBlocked = (ZERO_REG != 0) && (wrAddr == '0);
  assign wrLive    = wrEn && !wrBlocked;

  // Storage update; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wrLive) begin
      regs[wrAddr] <= wrData;
    end
  end

  // Read port 1: zero register, then bypass, then stored value.
  always_comb begin
    rdData1 = regs[rdAddr1];
    if ((ZERO_REG != 0) && (rdAddr1 == '0)) begin
      rdData1 = '0;
    end else if (wrLive && (wrAddr == rdAddr1)) begin
      rdData1 = wrData;
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rdData2 = regs[rdAddr2];
    if ((ZERO_REG != 0) && (rdAddr2 == '0)) begin
      rdData2 = '0;
    end else if (wrLive && (wrAddr == rdAddr2)) begin
      rdData2 = wrData;
    end
  end

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: splits the instruction, reads operands (with write-back
// bypass), sign-extends the immediate and registers everything into the
// ID/EX register. Load-use hazards against the held instruction insert a
// bubble and bump a saturating stall counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid/instruction are held by fetch until in_ready; out_*
// fields are held stable while out_valid & ~out_ready. in_ready is
// combinational on out_ready, flush and the incoming instruction.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int              DATA_W      = DEF_DATA_W,
  parameter int              OPC_W       = DEF_OPC_W,
  parameter int              REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int              IMM_W       = DEF_IMM_W,
  parameter int              INSTR_W     = OPC_W + 2 * REG_ADDR_W + IMM_W,
  parameter logic [OPC_W-1:0] LOAD_OPC   = OPC_W'(DEF_LOAD_OPC),
  parameter int              ZERO_REG    = DEF_ZERO_REG,
  parameter int              STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     instruction,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPC_W-1:0]       out_opc,
  output logic [REG_ADDR_W-1:0]  out_rs,
  output logic [REG_ADDR_W-1:0]  out_rt,
  output logic [REG_ADDR_W-1:0]  out_rd,
  output logic [DATA_W-1:0]      out_rd1,
  output logic [DATA_W-1:0]      out_rd2,
  output logic [DATA_W-1:0]      out_imm,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int RS_MSB = rsMsb(INSTR_W, OPC_W);
  localparam int RT_MSB = rtMsb(INSTR_W, OPC_W, REG_ADDR_W);

  logic [OPC_W-1:0]      opc;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [IMM_W-1:0]      imm;
  logic [DATA_W-1:0]     immExt;
  logic [DATA_W-1:0]     rd1;
  logic [DATA_W-1:0]     rd2;

  logic        loadHeld;
  logic        rtLive;
  logic        hazard;
  logic        adv;
  idexAction_e action;

  // Field split and sign extension of the incoming instruction.
  assign opc    = instruction[INSTR_W-1 -: OPC_W];
  assign rs     = instruction[RS_MSB -: REG_ADDR_W];
  assign rt     = instruction[RT_MSB -: REG_ADDR_W];
  assign imm    = instruction[IMM_W-1:0];
  assign rd     = imm[IMM_W-1 -: REG_ADDR_W];
  assign immExt = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};

  reg_file_bypass #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .wrEn    (wb_en),
    .wrAddr  (wb_addr),
    .wrData  (wb_data),
    .rdAddr1 (rs),
    .rdAddr2 (rt),
    .rdData1 (rd1),
    .rdData2 (rd2)
  );

  // A held load whose destination is a real register blocks any incoming
  // instruction that sources it; the loaded value is not ready yet.
  assign loadHeld = out_valid && (out_opc == LOAD_OPC);
  assign rtLive   = (out_rt != '0) || (ZERO_REG == 0);
  assign hazard   = in_valid && loadHeld && rtLive && ((out_rt == rs) || (out_rt == rt));
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv && !hazard && !flush;

  // Pick the ID/EX update for this edge; flush beats everything.
  always_comb begin
    action = ACT_HOLD;
    if (flush) begin
      action = ACT_FLUSH;
    end else if (adv && hazard) begin
      action = ACT_BUBBLE;
    end else if (adv && in_valid) begin
      action = ACT_LOAD;
    end else if (adv) begin
      action = ACT_DRAIN;
    end
  end

  // ID/EX register; bubbles and flushes only clear out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_opc   <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_rd    <= '0;
      out_rd1   <= '0;
      out_rd2   <= '0;
      out_imm   <= '0;
    end else begin
      case (action)
        ACT_FLUSH, ACT_BUBBLE, ACT_DRAIN: begin
          out_valid <= 1'b0;
        end
        ACT_LOAD: begin
          out_valid <= 1'b1;
          out_opc   <= opc;
          out_rs    <= rs;
          out_rt    <= rt;
          out_rd    <= rd;
          out_rd1   <= rd1;
          out_rd2   <= rd2;
          out_imm   <= immExt;
        end
        default: begin
          out_valid <= out_valid;
        end
      endcase
    end
  end

  // Saturating count of bubble cycles inserted for load-use hazards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if ((action == ACT_BUBBLE) && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed vectors, expected ID/EX contents queued
// at issue time and checked by a monitor whenever execute accepts.
module tb_decode_stage_p;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instruction;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opc;
  logic [2:0]  out_rs;
  logic [2:0]  out_rt;
  logic [2:0]  out_rd;
  logic [15:0] out_rd1;
  logic [15:0] out_rd2;
  logic [15:0] out_imm;
  logic [15:0] stall_count;

  // Second instance with a 2-bit stall counter, driven identically.
  logic        in_ready_s;
  logic        out_valid_s;
  logic [2:0]  out_opc_s;
  logic [2:0]  out_rs_s;
  logic [2:0]  out_rt_s;
  logic [2:0]  out_rd_s;
  logic [15:0] out_rd1_s;
  logic [15:0] out_rd2_s;
  logic [15:0] out_imm_s;
  logic [1:0]  stall_count_s;

  int checks = 0;
  int errors = 0;

  logic [59:0] exp_q[$];
  logic [59:0] junk;
  logic [59:0] exp_c;

  decode_stage_p dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opc(out_opc), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
    .stall_count(stall_count)
  );

  decode_stage_p #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .instruction(instruction), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_opc(out_opc_s), .out_rs(out_rs_s), .out_rt(out_rt_s), .out_rd(out_rd_s),
    .out_rd1(out_rd1_s), .out_rd2(out_rd2_s), .out_imm(out_imm_s),
    .stall_count(stall_count_s)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [2:0] o, input logic [2:0] s,
                                     input logic [2:0] t, input logic [6:0] i);
    return {o, s, t, i};
  endfunction

  function automatic logic [59:0] pk(input logic [2:0] o, input logic [2:0] s,
                                     input logic [2:0] t, input logic [2:0] d,
                                     input logic [15:0] r1, input logic [15:0] r2,
                                     input logic [15:0] im);
    return {o, s, t, d, r1, r2, im};
  endfunction

  function automatic logic [59:0] actual();
    return {out_opc, out_rs, out_rt, out_rd, out_rd1, out_rd2, out_imm};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted output must match the queue head.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", actual());
      end else begin
        junk = exp_q.pop_front();
        if (actual() !== junk) begin
          errors++;
          $display("FAIL idex_fields: got %0h expected %0h", actual(), junk);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; instruction = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'(actual()), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    chk("rst_stall_sat", 64'(stall_count_s), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Bypass: r3 written in the same cycle rs=3 is decoded.
    out_ready = 1'b1; in_valid = 1'b1;
    instruction = mk(3'd1, 3'd3, 3'd0, 7'h05);
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
    exp_q.push_back(pk(3'd1, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h0000, 16'h0005));
    tick();
    // Write to r0 is dropped and not bypassed; negative immediate.
    instruction = mk(3'd2, 3'd0, 3'd3, 7'h40);
    wb_addr = 3'd0; wb_data = 16'hFFFF;
    exp_q.push_back(pk(3'd2, 3'd0, 3'd3, 3'd4, 16'h0000, 16'h1234, 16'hFFC0));
    tick();
    // Later read of r0 still zero; positive immediate; write r2.
    instruction = mk(3'd2, 3'd0, 3'd0, 7'h3F);
    wb_addr = 3'd2; wb_data = 16'hBEEF;
    exp_q.push_back(pk(3'd2, 3'd0, 3'd0, 3'd3, 16'h0000, 16'h0000, 16'h003F));
    tick();
    wb_en = 1'b0;

    // Load-use: load rt=2 then rs=2.
    instruction = mk(3'd4, 3'd1, 3'd2, 7'h00);
    exp_q.push_back(pk(3'd4, 3'd1, 3'd2, 3'd0, 16'h0000, 16'hBEEF, 16'h0000));
    tick();
    instruction = mk(3'd1, 3'd2, 3'd5, 7'h01);
    exp_q.push_back(pk(3'd1, 3'd2, 3'd5, 3'd0, 16'hBEEF, 16'h0000, 16'h0001));
    #1;
    chk("lu_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    chk("lu_bubble_valid", 64'(out_valid), 64'd0);
    chk("lu_stall_one", 64'(stall_count), 64'd1);
    chk("lu_in_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("lu_second_valid", 64'(out_valid), 64'd1);

    // Back-pressure: C held for three edges with out_ready low.
    instruction = mk(3'd3, 3'd3, 3'd2, 7'h7F);
    exp_c = pk(3'd3, 3'd3, 3'd2, 3'd7, 16'h1234, 16'hBEEF, 16'hFFFF);
    exp_q.push_back(exp_c);
    tick();
    out_ready = 1'b0;
    instruction = mk(3'd5, 3'd1, 3'd1, 7'h10);
    exp_q.push_back(pk(3'd5, 3'd1, 3'd1, 3'd1, 16'h0000, 16'h0000, 16'h0010));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'(actual()), 64'(exp_c));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();

    // Flush kills the held D and refuses E.
    out_ready = 1'b0; flush = 1'b1;
    instruction = mk(3'd1, 3'd2, 3'd2, 7'h00);
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    junk = exp_q.pop_front();
    flush = 1'b0; out_ready = 1'b1;
    exp_q.push_back(pk(3'd1, 3'd2, 3'd2, 3'd0, 16'hBEEF, 16'hBEEF, 16'h0000));
    #1;
    chk("fl_represent_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fl_accept_valid", 64'(out_valid), 64'd1);

    // Load into r0 never causes a hazard.
    instruction = mk(3'd4, 3'd0, 3'd0, 7'h00);
    exp_q.push_back(pk(3'd4, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000));
    tick();
    instruction = mk(3'd1, 3'd0, 3'd0, 7'h00);
    exp_q.push_back(pk(3'd1, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000));
    #1;
    chk("r0_no_hazard", 64'(in_ready), 64'd1);
    tick();

    // Four more load-use stalls, matching on rt of the consumer.
    for (int i = 0; i < 4; i++) begin
      instruction = mk(3'd4, 3'd0, 3'd6, 7'h00);
      exp_q.push_back(pk(3'd4, 3'd0, 3'd6, 3'd0, 16'h0000, 16'h0000, 16'h0000));
      tick();
      instruction = mk(3'd1, 3'd0, 3'd6, 7'h00);
      exp_q.push_back(pk(3'd1, 3'd0, 3'd6, 3'd0, 16'h0000, 16'h0000, 16'h0000));
      #1;
      chk("sat_in_ready_low", 64'(in_ready), 64'd0);
      tick();
      chk("sat_bubble", 64'(out_valid), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("sat_stall_wide", 64'(stall_count), 64'd5);
    chk("sat_stall_narrow", 64'(stall_count_s), 64'd3);
    tick();
    tick();

    // Async reset between edges with an instruction held.
    out_ready = 1'b0; in_valid = 1'b1;
    instruction = mk(3'd3, 3'd1, 3'd2, 7'h12);
    tick();
    in_valid = 1'b0;
    chk("ar_held_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_fields", 64'(actual()), 64'd0);
    chk("ar_stall", 64'(stall_count), 64'd0);
    chk("ar_stall_narrow", 64'(stall_count_s), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Register file was cleared by reset.
    out_ready = 1'b1; in_valid = 1'b1;
    instruction = mk(3'd1, 3'd3, 3'd2, 7'h00);
    exp_q.push_back(pk(3'd1, 3'd3, 3'd2, 3'd0, 16'h0000, 16'h0000, 16'h0000));
    tick();
    in_valid = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      tick();
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised, pipelined decode stage for the 16-bit MIPS-style core. It splits the instruction into fields, reads two operands from an internal register file with same-cycle write-back bypass, and sign-extends the immediate. Results are registered into a valid/ready ID/EX pipeline register. It also detects load-use hazards against the instruction it currently holds, inserts bubbles for them, and counts stall cycles. It sits between fetch and execute.

## Interface
Parameters:
- DATA_W, 16, register and operand width
- OPC_W, 3, opcode field width
- REG_ADDR_W, 3, register index width; the register file holds 2**REG_ADDR_W entries
- IMM_W, 7, immediate field width; rd is the top REG_ADDR_W bits of it
- INSTR_W, OPC_W+2*REG_ADDR_W+IMM_W, instruction width (16 at defaults)
- LOAD_OPC, 3'b100, opcode whose result is written to rt and arrives late (load)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes
- STALL_CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  decode accepts this cycle
- instruction  in  INSTR_W  fields: opc [top], rs, rt, imm [bottom]
- flush  in  1  kill the held instruction (branch taken)
- wb_en  in  1  write-back enable
- wb_addr  in  REG_ADDR_W  write-back register
- wb_data  in  DATA_W  write-back value
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  execute accepts
- out_opc  out  OPC_W  registered opcode
- out_rs, out_rt, out_rd  out  REG_ADDR_W  registered register indices
- out_rd1, out_rd2  out  DATA_W  registered operands (rs, rt)
- out_imm  out  DATA_W  registered sign-extended immediate
- stall_count  out  STALL_CNT_W  saturating count of hazard-stall cycles

## Operation
- **Field split:** opc = instruction[INSTR_W-1 -: OPC_W]; rs and rt follow; imm = instruction[IMM_W-1:0]; rd = imm[IMM_W-1 -: REG_ADDR_W].
- **Sign extension:** imm bit IMM_W-1 is replicated up to DATA_W.
- **Register file writes:** on the clock edge when wb_en is high, except that address 0 is ignored when ZERO_REG=1.
- **Register file reads:** combinational.
- **Write-back bypass:** when wb_en is high and wb_addr equals a read address, wb_data is returned on that read in the same cycle. No bypass for address 0 when ZERO_REG=1.
- **Hazard:** hazard = in_valid & out_valid & (out_opc==LOAD_OPC) & (out_rt!=0 | ZERO_REG==0) & (out_rt==rs | out_rt==rt).
- **Advance:** adv = out_ready | ~out_valid. in_ready = adv & ~hazard & ~flush.
- **Per-edge priority** (for the ID/EX register):
  1. flush: out_valid←0.
  2. adv & hazard: out_valid←0 (bubble), stall_count++.
  3. adv & in_valid: load all fields, out_valid←1.
  4. adv: out_valid←0.
  5. Otherwise hold all fields.
- **Field contents on bubble/flush:** data fields hold their last value; only out_valid is meaningful.
- **Stall counter:** saturates at all-ones and does not wrap. It increments only in case 2.
- **Reset:** out_valid=0, every out_* field=0, stall_count=0, every register-file entry=0. in_ready is 1 once out_valid=0 and no flush is asserted.
- **Flush with in_valid:** the instruction is not accepted (in_ready=0); fetch must re-present it.
- **Reset mid-transfer:** the held instruction is lost. No partial state survives.

## Timing
- Latency: 1 cycle from accept (in_valid & in_ready) to out_valid with the decoded data.
- Throughput: 1 instruction per cycle with no hazard and out_ready held high.
- Load-use: exactly 1 bubble cycle when out_ready=1. The stall persists for as long as the load is held by out_ready=0.
- Back-pressure: out_* fields are stable while out_valid & ~out_ready.
- in_ready depends combinationally on out_ready, flush, and the incoming instruction.

## Structure
- **Package decode_pkg:** default width parameters, LOAD_OPC, and the field-offset localparams.
- **Sub-module reg_file_bypass:** parametrised by DATA_W, REG_ADDR_W and ZERO_REG; two read ports, one write port, with bypass.
- **decode_stage_p** holds the field split, sign extension, hazard logic, ID/EX register and stall counter.

## Test plan
- **Reset and bypass:** after reset, write r3=0x1234 via wb_en in the same cycle as decoding an instruction with rs=3 → out_rd1=0x1234 one cycle later. Writing r0=0xFFFF → a later read of r0 returns 0.
- **Sign extension:** imm=7'h40 → out_imm=0xFFC0; imm=7'h3F → out_imm=0x003F.
- **Load-use:** load with rt=2, followed by an instruction with rs=2, out_ready=1 → one cycle of out_valid=0 and in_ready=0, stall_count 0→1, and the second instruction appears on the next cycle.
- **Back-pressure:** hold out_ready=0 for 3 cycles with out_valid=1 → all out_* fields unchanged and in_ready=0. Release → the next instruction is accepted.
- **Flush:** assert flush while out_valid=1 and in_valid=1 → out_valid=0 on the next cycle and the instruction is not accepted.
- **Saturation and async reset:** with STALL_CNT_W=2, four load-use stalls → stall_count=3. Assert rst between clock edges → all outputs clear immediately.
